// File: rtl/chunked_sum_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder.
package chunked_sum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of CHUNK-wide slices needed to cover all addends.
    function automatic int nchunk_f(input int naddends, input int chunk);
        return (naddends + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/logs_sum.sv
// Combinational log-depth adder tree, wrapping modulo 2^NBITS.
module logs_sum #(
    parameter int NADDENDS = 4,
    parameter int NBITS    = 3
) (
    input  logic [NADDENDS-1:0][NBITS-1:0] addends,
    output logic [NBITS-1:0]               sum
);

    localparam int P = 2 ** $clog2(NADDENDS);

    // Heap layout: leaves at [P..2P-1], node k sums children 2k and 2k+1.
    logic [NBITS-1:0] node [2*P];

    always_comb begin
        for (int i = 0; i < 2 * P; i++) node[i] = '0;
        for (int i = 0; i < NADDENDS; i++) node[P + i] = addends[i];
        for (int k = P - 1; k >= 1; k--) node[k] = node[2 * k] + node[2 * k + 1];
    end

    assign sum = node[1];

endmodule

// File: rtl/chunked_sum.sv
// Sums NADDENDS operands over NCHUNK cycles through one shared CHUNK-wide tree.
module chunked_sum
    import chunked_sum_pkg::*;
#(
    parameter int NBITS    = 3,
    parameter int NADDENDS = 24,
    parameter int CHUNK    = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NADDENDS-1:0][NBITS-1:0] addends,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NBITS-1:0]               sum
);

    localparam int NCHUNK = nchunk_f(NADDENDS, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = CHUNK * NBITS;
    localparam int FLATW  = NCHUNK * CW;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [FLATW-1:0] ops;
    logic [NBITS-1:0] acc;
    logic [NBITS-1:0] tree_sum;
    logic [CW-1:0]    chunk_bits;
    logic             last;

    // Operand register is zero-extended, so the tail chunk is implicitly padded.
    assign chunk_bits = ops[idx * CW +: CW];
    assign last       = (idx == IDXW'(NCHUNK - 1));

    logs_sum #(
        .NADDENDS(CHUNK),
        .NBITS   (NBITS)
    ) u_tree (
        .addends(chunk_bits),
        .sum    (tree_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            ops   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ops   <= FLATW'(addends);
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + tree_sum;
                    idx <= idx + 1'b1;
                    if (last) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = acc;

endmodule

// File: tb/tb_chunked_sum.sv
// Directed checks of chunked_sum in three parameterisations.
module tb_chunked_sum;

    logic clk = 1'b0;
    logic rst_n;
    logic out_ready;
    logic iv [3];
    logic ir [3];
    logic ov [3];
    logic [2:0] sm [3];
    logic [23:0][2:0] a0;
    logic [6:0][2:0]  a1;
    logic [23:0][2:0] a2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chunked_sum dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .addends(a0), .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0])
    );

    chunked_sum #(.NBITS(3), .NADDENDS(7), .CHUNK(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .addends(a1), .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1])
    );

    chunked_sum #(.NBITS(3), .NADDENDS(24), .CHUNK(24)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .addends(a2), .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2])
    );

    // Offer one job to DUT `w`; report cycles from accept to out_valid (20 = timeout).
    task automatic run_job(input int w, output int lat, output logic rdy, output logic [2:0] s);
        @(negedge clk);
        iv[w] = 1'b1;
        @(posedge clk);
        #1;
        iv[w] = 1'b0;
        rdy = ir[w];
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov[w] && lat < 20);
        s = sm[w];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int w = 0; w < 3; w++) begin
            n_cmp++; if (ir[w] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d] got %b want 1", w, ir[w]); end
            n_cmp++; if (ov[w] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d] got %b want 0", w, ov[w]); end
            n_cmp++; if (sm[w] !== 3'd0) begin n_bad++; $display("FAIL reset_sum[%0d] got %0d want 0", w, sm[w]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        int lat; logic rdy; logic [2:0] s;
        for (int i = 0; i < 24; i++) a0[i] = 3'd1;
        run_job(0, lat, rdy, s);
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL ones_in_ready_busy got %b want 0", rdy); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ones_latency got %0d want 4", lat); end
        n_cmp++; if (s !== 3'd0) begin n_bad++; $display("FAIL ones_sum got %0d want 0", s); end
        @(posedge clk); #1;
        n_cmp++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin n_bad++; $display("FAIL ones_back_idle got rdy=%b vld=%b want 1/0", ir[0], ov[0]); end
    endtask

    task automatic test_ramp();
        int lat; logic rdy; logic [2:0] s;
        for (int i = 0; i < 24; i++) a0[i] = 3'(i % 8);
        run_job(0, lat, rdy, s);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ramp_latency got %0d want 4", lat); end
        n_cmp++; if (s !== 3'd4) begin n_bad++; $display("FAIL ramp_sum got %0d want 4", s); end
    endtask

    task automatic test_padding();
        int lat; logic rdy; logic [2:0] s;
        for (int i = 0; i < 7; i++) a1[i] = 3'd7;
        run_job(1, lat, rdy, s);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL pad_latency got %0d want 3", lat); end
        n_cmp++; if (s !== 3'd1) begin n_bad++; $display("FAIL pad_sum got %0d want 1", s); end
    endtask

    task automatic test_single_chunk();
        int lat; logic rdy; logic [2:0] s;
        for (int i = 0; i < 24; i++) a2[i] = 3'd5;
        run_job(2, lat, rdy, s);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL single_latency got %0d want 1", lat); end
        n_cmp++; if (s !== 3'd0) begin n_bad++; $display("FAIL single_sum got %0d want 0", s); end
    endtask

    task automatic test_stall();
        int lat; logic rdy; logic [2:0] s;
        int bad;
        a0 = '0;
        a0[0] = 3'd5;
        out_ready = 1'b0;
        run_job(0, lat, rdy, s);
        n_cmp++; if (s !== 3'd5 || lat !== 4) begin n_bad++; $display("FAIL stall_result got sum=%0d lat=%0d want 5/4", s, lat); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 24; i++) a0[i] = 3'd3;
            iv[0] = (c == 3);
            @(posedge clk); #1;
            if (ov[0] !== 1'b1 || sm[0] !== 3'd5 || ir[0] !== 1'b0) bad++;
        end
        iv[0] = 1'b0;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin n_bad++; $display("FAIL stall_release got vld=%b rdy=%b want 0/1", ov[0], ir[0]); end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin n_bad++; $display("FAIL stall_ignored_job got vld=%b rdy=%b want 0/1", ov[0], ir[0]); end
    endtask

    task automatic test_reset_mid();
        int lat; logic rdy; logic [2:0] s;
        int seen;
        for (int i = 0; i < 24; i++) a0[i] = 3'd1;
        @(negedge clk);
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || sm[0] !== 3'd0) begin n_bad++; $display("FAIL midrst_async got rdy=%b vld=%b sum=%0d want 1/0/0", ir[0], ov[0], sm[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (ov[0] !== 1'b0) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); end
        for (int i = 0; i < 24; i++) a0[i] = 3'(i % 8);
        run_job(0, lat, rdy, s);
        n_cmp++; if (s !== 3'd4 || lat !== 4) begin n_bad++; $display("FAIL midrst_next_job got sum=%0d lat=%0d want 4/4", s, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int first, second, c;
        first = -1; second = -1;
        for (int i = 0; i < 24; i++) a0[i] = 3'd2;
        @(negedge clk);
        iv[0] = 1'b1;
        c = 0;
        while (c < 30 && second < 0) begin
            @(posedge clk); #1;
            c++;
            if (ov[0] === 1'b1) begin
                if (first < 0) first = c; else second = c;
            end
        end
        iv[0] = 1'b0;
        n_cmp++; if (first !== 5) begin n_bad++; $display("FAIL b2b_first got cycle %0d want 5", first); end
        n_cmp++; if (second !== 11) begin n_bad++; $display("FAIL b2b_spacing got cycle %0d want 11", second); end
        n_cmp++; if (sm[0] !== 3'd0) begin n_bad++; $display("FAIL b2b_sum got %0d want 0", sm[0]); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int w = 0; w < 3; w++) iv[w] = 1'b0;
        out_ready = 1'b1;
        a0 = '0; a1 = '0; a2 = '0;
        test_reset();
        test_all_ones();
        test_ramp();
        test_padding();
        test_single_chunk();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chunked_sum.md
CHUNKED_SUM -- requirements
Module: chunked_sum

Interface
REQ-001 Parameter NBITS, default 3: width of each addend, the accumulator and the result.
REQ-002 Parameter NADDENDS, default 24: number of addends per job; SHALL be >= 1.
REQ-003 Parameter CHUNK, default 6: addends summed per cycle by the shared adder tree; SHALL be >= 1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  job offered on addends.
REQ-007 in_ready  output  1  block can accept a job.
REQ-008 addends  input  [NADDENDS-1:0][NBITS-1:0]  job operands; sampled only at acceptance.
REQ-009 out_valid  output  1  sum holds a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  NBITS  result, modulo 2^NBITS.

Function
REQ-012 NCHUNK SHALL be ceil(NADDENDS/CHUNK); the last chunk SHALL be zero-padded to CHUNK entries.
REQ-013 FSM states: IDLE, ACCUM, DONE; in_ready SHALL be 1 exactly in IDLE, out_valid SHALL be 1 exactly in DONE.
REQ-014 IDLE: on in_valid&&in_ready, the block SHALL capture addends into an operand register, clear the accumulator, set chunk index to 0 and go to ACCUM; otherwise it SHALL stay in IDLE.
REQ-015 ACCUM: each cycle accumulator <= accumulator + tree-sum of chunk[index], index <= index+1; after chunk NCHUNK-1 the block SHALL go to DONE.
REQ-016 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accepting edge (NCHUNK=1 gives DONE on the next cycle).
REQ-017 DONE: sum SHALL stay stable while out_valid=1 and out_ready=0; on out_ready=1 the block SHALL go to IDLE.
REQ-018 A new job SHALL not be accepted in the DONE->IDLE transition cycle; minimum job spacing is NCHUNK+2 cycles.
REQ-019 All additions SHALL wrap modulo 2^NBITS; no carry or overflow flag exists.
REQ-020 Changes on addends or in_valid while not in IDLE SHALL have no effect.
REQ-021 sum SHALL equal the accumulator register; its value outside DONE is don't-care to consumers but SHALL be deterministic.

Reset
REQ-022 While rst_n=0: state=IDLE, accumulator=0, index=0, operand register=0, in_ready=1, out_valid=0, sum=0.
REQ-023 Reset asserted mid-ACCUM or in DONE SHALL discard the job immediately; no result SHALL be delivered for it.
REQ-024 After rst_n deasserts, the first job SHALL be acceptable on the first rising edge.

Structure
REQ-025 Package chunked_sum_pkg SHALL hold the FSM state typedef (IDLE, ACCUM, DONE) and a function computing NCHUNK.
REQ-026 Exactly one instance of the existing logs_sum module with NADDENDS=CHUNK, NBITS=NBITS SHALL form the per-cycle datapath; index width SHALL be $clog2(NCHUNK), minimum 1.

Verification
REQ-027 Defaults, all addends=1, out_ready=1 -> out_valid 4 cycles after accept, sum=0 (24 mod 8).
REQ-028 Defaults, addend[i]=i mod 8 -> sum=(3*(0+..+7)) mod 8 = 84 mod 8 = 4.
REQ-029 NADDENDS=7, CHUNK=3, addends=7 each -> NCHUNK=3, sum=49 mod 8=1, padding contributes 0.
REQ-030 out_ready held 0 for 10 cycles in DONE -> sum and out_valid stable, in_ready=0, second in_valid ignored; out_ready pulse -> IDLE next cycle.
REQ-031 rst_n pulsed low during index 2 -> outputs at reset values asynchronously, no out_valid; next job produces correct sum.
REQ-032 CHUNK=24 (NCHUNK=1), addends=5 each -> out_valid one cycle after accept, sum=120 mod 8=0.
